rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin, 1 = requester 0 always wins.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have ports req0_valid in 1, req0_addr in 5, req0_data in 32, req0_ready out 1 (requester 0, core writeback).
REQ-005 The block SHALL have ports req1_valid in 1, req1_addr in 5, req1_data in 32, req1_ready out 1 (requester 1, load/debug).
REQ-006 The block SHALL have port clr, input, 1, a one-cycle pulse that restarts the clear sweep.
REQ-007 The block SHALL have ports we3 out 1, a3 out 5, wd3 out 32; all registered and driving the register file write port.
REQ-008 The block SHALL have port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-009 The FSM SHALL have two states: CLEAR (clear sweep) and ARB (serving requesters).
REQ-010 A handshake on requester X SHALL occur at a rising edge where reqX_valid and reqX_ready are both 1.
REQ-011 reqX_ready SHALL be combinational and high only in ARB when requester X holds the grant.
REQ-012 In ARB, the grant SHALL go to the only valid requester when exactly one is valid; with none valid, no grant.
REQ-013 Both valid, FIXED_PRIO=0: the grant SHALL go to the requester not granted last; the last-grant pointer updates on every handshake.
REQ-014 Both valid, FIXED_PRIO=1: the grant SHALL go to requester 0; requester 1 may starve.
REQ-015 A handshake at edge N SHALL drive we3=1, a3=addr, wd3=data for exactly the cycle after edge N; the register file commits at edge N+1.
REQ-016 In cycles without a handshake, we3 SHALL be 0; a3 and wd3 SHALL hold their last values.
REQ-017 A handshake with addr=0 SHALL complete normally (ready asserted, pointer updated) but SHALL leave we3=0 (x0 write dropped).
REQ-018 Requesters SHALL hold valid/addr/data stable until the handshake; the block SHALL NOT latch any unaccepted request.
REQ-019 Back-to-back handshakes SHALL be sustained at one per cycle; alternating grants under continuous contention when FIXED_PRIO=0.
REQ-020 In CLEAR, both readies SHALL be 0; an internal 5-bit counter SHALL issue we3=1, a3=1..31 (ascending), wd3=0, one per cycle.
REQ-021 After the a3=31 write cycle is issued, the FSM SHALL enter ARB at the next edge; busy SHALL equal (state==CLEAR).
REQ-022 A clr pulse in ARB SHALL enter CLEAR at the next edge and win over any same-cycle request, whose ready stays 0; clr during CLEAR SHALL be ignored.

Reset
REQ-023 rst=1 SHALL immediately force we3=0, a3=0, wd3=0, the sweep counter to 1, and the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-024 Reset state SHALL be CLEAR with busy=1 when RF_CLEAR_EN is defined, else ARB with busy=0.
REQ-025 Assertion of rst mid-sweep or mid-write SHALL abort the operation; after release, the block SHALL restart from the REQ-024 state.

Configuration
REQ-026 With macro RF_CLEAR_EN defined, the CLEAR state, sweep counter and clr input SHALL be compiled in per REQ-020..022.
REQ-027 Without RF_CLEAR_EN, CLEAR SHALL be absent; clr SHALL be ignored, busy tied 0, and the FSM permanently in ARB.

Verification
REQ-028 RF_CLEAR_EN defined, release rst -> busy=1 for 31 cycles, we3=1 with a3=1,2,...,31 and wd3=0, then busy=0 and readies enabled.
REQ-029 FIXED_PRIO=0, both valid continuously (req0 addr 5 data 0xAAAA0000, req1 addr 6 data 0x5555FFFF) -> grants 0,1,0,1; we3 cycles show a3=5,6,5,6 with matching data.
REQ-030 FIXED_PRIO=1, same stimulus -> req1_ready never 1; every we3 cycle shows a3=5.
REQ-031 req1 valid addr 0 data 0xDEADBEEF -> req1_ready=1 for one cycle, we3 stays 0, next tie grants req0.
REQ-032 clr pulsed while req0 valid -> req0_ready=0, a full 31-write sweep runs, then req0 is accepted in the cycle after busy falls.
REQ-033 rst asserted mid-sweep at a3=12 -> outputs zero with no clock edge; after release, the sweep restarts at a3=1.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Two-requester register-file write-port arbiter (round-robin or fixed priority).
// Define RF_CLEAR_EN to compile in the x1..x31 zeroing sweep run after reset and on clr.
module rf_wr_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        clr,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic        busy
);

  typedef enum logic [0:0] {StClear, StArb} state_e;

  state_e      r_state;
  logic [4:0]  r_cnt;
  logic        r_last;
  logic        r_we3;
  logic [4:0]  r_a3;
  logic [31:0] r_wd3;

  logic w_clr_go;
  logic w_open;
  logic w_tie0;
  logic w_gnt0;
  logic w_gnt1;

`ifdef RF_CLEAR_EN
  localparam state_e ResetState = StClear;
  assign w_clr_go = clr && (r_state == StArb);
  assign busy     = (r_state == StClear);
`else
  localparam state_e ResetState = StArb;
  logic w_unused_clr;
  assign w_unused_clr = clr;
  assign w_clr_go     = 1'b0;
  assign busy         = 1'b0;
`endif

  // A clr pulse steals the cycle from any requester.
  assign w_open = (r_state == StArb) && !w_clr_go;
  assign w_tie0 = (FIXED_PRIO != 0) || r_last;
  assign w_gnt0 = w_open && req0_valid && (!req1_valid || w_tie0);
  assign w_gnt1 = w_open && req1_valid && (!req0_valid || !w_tie0);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign we3        = r_we3;
  assign a3         = r_a3;
  assign wd3        = r_wd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ResetState;
      r_cnt   <= 5'd1;
      r_last  <= 1'b1;
      r_we3   <= 1'b0;
      r_a3    <= 5'd0;
      r_wd3   <= 32'd0;
    end else begin
      case (r_state)
        StClear: begin
          r_we3 <= 1'b1;
          r_a3  <= r_cnt;
          r_wd3 <= 32'd0;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= StArb;
          end
        end
        default: begin
          r_we3 <= 1'b0;
          if (w_clr_go) begin
            r_state <= StClear;
            r_cnt   <= 5'd1;
          end else if (w_gnt0) begin
            r_last <= 1'b0;
            // x0 writes complete the handshake but never reach the register file.
            if (req0_addr != 5'd0) begin
              r_we3 <= 1'b1;
              r_a3  <= req0_addr;
              r_wd3 <= req0_data;
            end
          end else if (w_gnt1) begin
            r_last <= 1'b1;
            if (req1_addr != 5'd0) begin
              r_we3 <= 1'b1;
              r_a3  <= req1_addr;
              r_wd3 <= req1_data;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: round-robin and fixed-priority instances side by side,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_rf_wr_arbiter;

`ifdef RF_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, clr;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic [1:0]  rdy0, rdy1, we3, busy;
  logic [4:0]  a3 [2];
  logic [31:0] wd3 [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0[0]),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1[0]),
    .clr(clr), .we3(we3[0]), .a3(a3[0]), .wd3(wd3[0]), .busy(busy[0])
  );

  rf_wr_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0[1]),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1[1]),
    .clr(clr), .we3(we3[1]), .a3(a3[1]), .wd3(wd3[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, p, act, exp, $time);
    end
  endtask

  // Model state per instance: index 0 round-robin, index 1 fixed priority.
  int          m_left [2];  // sweep writes still to issue; 0 means serving requesters
  bit          m_last [2];
  bit          m_we   [2];
  logic [4:0]  m_a    [2];
  logic [31:0] m_wd   [2];

  function automatic bit exp_rdy(input int p, input int x);
    bit to0;
    if (m_left[p] != 0 || (ClrEn && clr)) return 1'b0;
    if (req0_valid && req1_valid) to0 = (p == 1) || m_last[p];
    else to0 = req0_valid;
    return (x == 0) ? (req0_valid && to0) : (req1_valid && !to0);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit g0, g1;
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        m_left[p] = ClrEn ? 31 : 0;
        m_last[p] = 1'b1;
        m_we[p]   = 1'b0;
        m_a[p]    = 5'd0;
        m_wd[p]   = 32'd0;
      end else begin
        g0 = exp_rdy(p, 0);
        g1 = exp_rdy(p, 1);
        if (m_left[p] > 0) begin
          m_we[p] = 1'b1;
          m_a[p]  = 5'(32 - m_left[p]);
          m_wd[p] = 32'd0;
          m_left[p]--;
        end else if (ClrEn && clr) begin
          m_left[p] = 31;
          m_we[p]   = 1'b0;
        end else if (g0 || g1) begin
          m_last[p] = g1;
          m_we[p]   = g0 ? (req0_addr != 0) : (req1_addr != 0);
          if (m_we[p]) begin
            m_a[p]  = g0 ? req0_addr : req1_addr;
            m_wd[p] = g0 ? req0_data : req1_data;
          end
        end else begin
          m_we[p] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        chk("req0_ready", p, 32'(rdy0[p]), 32'(exp_rdy(p, 0)));
        chk("req1_ready", p, 32'(rdy1[p]), 32'(exp_rdy(p, 1)));
        chk("busy", p, 32'(busy[p]), 32'(m_left[p] != 0));
        chk("we3", p, 32'(we3[p]), 32'(m_we[p]));
        chk("a3", p, 32'(a3[p]), 32'(m_a[p]));
        chk("wd3", p, wd3[p], m_wd[p]);
      end
    end
  end

  wr_t q_rr[$];
  wr_t q_fp[$];
  int  r1_cnt [2];
  int  busy_cnt [2];

  always @(negedge clk) begin
    if (!rst) begin
      if (we3[0]) q_rr.push_back('{a: a3[0], d: wd3[0]});
      if (we3[1]) q_fp.push_back('{a: a3[1], d: wd3[1]});
      for (int p = 0; p < 2; p++) begin
        if (rdy1[p]) r1_cnt[p]++;
        if (busy[p]) busy_cnt[p]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q_rr.delete();
    q_fp.delete();
    for (int p = 0; p < 2; p++) begin
      r1_cnt[p]   = 0;
      busy_cnt[p] = 0;
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    for (int p = 0; p < 2; p++) begin
      chk({nm, "_we3"}, p, 32'(we3[p]), 32'd0);
      chk({nm, "_a3"}, p, 32'(a3[p]), 32'd0);
      chk({nm, "_wd3"}, p, wd3[p], 32'd0);
      chk({nm, "_busy"}, p, 32'(busy[p]), 32'(ClrEn));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    logic [4:0] exp_a [4];
    logic [31:0] exp_d [4];
    rst = 1'b1; clr = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    #1;
    chk_zero_outputs("reset");
    step(2);
    rst = 1'b0;
    clear_logs();
    #1;
    chk_zero_outputs("release");

`ifdef RF_CLEAR_EN
    step(40);
    chk("sweep_busy_cycles", 0, busy_cnt[0], 31);
    chk("sweep_count", 0, q_rr.size(), 31);
    errs = 0;
    foreach (q_rr[k]) if (q_rr[k].a != 5'(k + 1) || q_rr[k].d != 0) errs++;
    chk("sweep_sequence", 0, errs, 0);
`else
    step(2);
`endif

    // Continuous contention: round-robin alternates, fixed priority starves requester 1.
    clear_logs();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hAAAA_0000;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h5555_FFFF;
    step(4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(2);
    exp_a = '{5'd5, 5'd6, 5'd5, 5'd6};
    exp_d = '{32'hAAAA_0000, 32'h5555_FFFF, 32'hAAAA_0000, 32'h5555_FFFF};
    chk("rr_write_count", 0, q_rr.size(), 4);
    errs = 0;
    foreach (q_rr[k]) if (k > 3 || q_rr[k].a != exp_a[k] || q_rr[k].d != exp_d[k]) errs++;
    chk("rr_alternation", 0, errs, 0);
    chk("fp_write_count", 1, q_fp.size(), 4);
    errs = 0;
    foreach (q_fp[k]) if (q_fp[k].a != 5'd5 || q_fp[k].d != 32'hAAAA_0000) errs++;
    chk("fp_always_req0", 1, errs, 0);
    chk("fp_req1_starved", 1, r1_cnt[1], 0);

    // x0 write: handshake completes, nothing is written, pointer still advances.
    clear_logs();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hDEAD_BEEF;
    step(1);
    req1_valid = 1'b0;
    step(2);
    chk("x0_ready_cycles", 0, r1_cnt[0], 1);
    chk("x0_no_write", 0, q_rr.size(), 0);
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_0505;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h0000_0606;
    step(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(1);
    chk("x0_then_tie_count", 0, q_rr.size(), 1);
    if (q_rr.size() > 0) chk("x0_then_tie_req0", 0, 32'(q_rr[0].a), 32'd5);

    // clr pulse with a pending request.
    clear_logs();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1234_5678; clr = 1'b1;
    #1;
    chk("clr_blocks_ready", 0, 32'(rdy0[0]), 32'(!ClrEn));
    step(1);
    clr = 1'b0;
`ifdef RF_CLEAR_EN
    n = 0;
    while (n < 100 && !rdy0[0]) begin
      step(1);
      n++;
    end
    chk("clr_wait_bound", 0, 32'(n < 100), 32'd1);
    step(1);
`endif
    req0_valid = 1'b0;
    step(1);
    chk("clr_writes", 0, q_rr.size(), ClrEn ? 32 : 1);
    if (q_rr.size() > 0) chk("clr_then_req0", 0, 32'(q_rr[q_rr.size()-1].a), 32'd7);
`ifdef RF_CLEAR_EN
    chk("clr_busy_cycles", 0, busy_cnt[0], 31);

    // Reset in the middle of a sweep.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (we3[0] && a3[0] == 5'd12) break;
      n++;
    end
    chk("mid_sweep_bound", 0, 32'(n < 100), 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("mid_sweep_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    step(40);
    chk("restart_count", 0, q_rr.size(), 31);
    if (q_rr.size() > 0) chk("restart_first_a3", 0, 32'(q_rr[0].a), 32'd1);
`else
    // Reset in the middle of a write cycle.
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0909;
    step(1);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("mid_write_we3", 0, 32'(we3[0]), 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("mid_write_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
